// File: rtl/decode_inst_queue.sv
// -----------------------------------------------------------------------------
// decode_inst_queue
//
// Multi-lane in-order instruction queue between fetch and decode. Fetch writes
// up to IN_WIDTH instructions per cycle into a circular buffer. The OUT_WIDTH
// oldest entries are presented to the decode lanes, and decode consumes any
// prefix of them.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   flush       discard every entry on this edge (wins over enqueue/dequeue)
//   in_valid    per-lane fetch valid, contiguous from lane 0
//   in_inst     fetched instructions, lane i at [i*XLEN +: XLEN]
//   in_pc       fetched pcs, same packing
//   in_exc      fetch exception codes, lane i at [i*EXC_W +: EXC_W]
//   in_allowin  a full IN_WIDTH group fits this cycle
//   out_valid   per-lane valid toward decode, contiguous from lane 0
//   out_inst    head instructions, oldest in lane 0
//   out_pc      head pcs
//   out_exc     head exception codes
//   out_take    number of lanes decode consumes this cycle
//   count       current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module decode_inst_queue #(
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int XLEN      = 32,
    parameter int EXC_W     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [IN_WIDTH-1:0]              in_valid,
    input  logic [IN_WIDTH*XLEN-1:0]         in_inst,
    input  logic [IN_WIDTH*XLEN-1:0]         in_pc,
    input  logic [IN_WIDTH*EXC_W-1:0]        in_exc,
    output logic                             in_allowin,
    output logic [OUT_WIDTH-1:0]             out_valid,
    output logic [OUT_WIDTH*XLEN-1:0]        out_inst,
    output logic [OUT_WIDTH*XLEN-1:0]        out_pc,
    output logic [OUT_WIDTH*EXC_W-1:0]       out_exc,
    input  logic [$clog2(OUT_WIDTH+1)-1:0]   out_take,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage
    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [EXC_W-1:0] exc_q  [DEPTH];

    // Queue control state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Enqueue / presentation helpers
    logic                enq_en;
    logic [CNT_W-1:0]    enq_n;
    logic [IN_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0]    wr_idx [IN_WIDTH];
    logic [PTR_W-1:0]    rd_idx [OUT_WIDTH];

    // Admission looks only at the registered occupancy, so there is no
    // combinational path from out_take back to fetch.
    assign in_allowin = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_WIDTH);
    assign enq_en     = in_allowin && !flush;
    assign count      = count_q;

    // Each valid lane lands at tail + (its rank among valid lanes).
    // NOTE: every variable written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        enq_n = '0;
        wr_en = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_idx[i] = tail_q + PTR_W'(enq_n);
            wr_en[i]  = enq_en && in_valid[i];
            if (in_valid[i]) begin
                enq_n = enq_n + CNT_W'(1);
            end
        end
        if (!enq_en) begin
            enq_n = '0;
        end
    end

    // Pointers wrap naturally at PTR_W bits; flush overrides everything.
    always_comb begin
        head_d  = head_q + PTR_W'(out_take);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + enq_n - CNT_W'(out_take);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array is deliberately left out of reset; out_valid
    // masks stale contents, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (wr_en[i]) begin
                // A faulting fetch carries no usable instruction word.
                inst_q[wr_idx[i]] <= (in_exc[i*EXC_W +: EXC_W] != '0) ? '0
                                     : in_inst[i*XLEN +: XLEN];
                pc_q[wr_idx[i]]   <= in_pc[i*XLEN +: XLEN];
                exc_q[wr_idx[i]]  <= in_exc[i*EXC_W +: EXC_W];
            end
        end
    end

    // Head presentation straight from registered storage, no bypass.
    always_comb begin
        for (int j = 0; j < OUT_WIDTH; j++) begin
            rd_idx[j]                     = head_q + PTR_W'(j);
            out_valid[j]                  = CNT_W'(j) < count_q;
            out_inst[j*XLEN +: XLEN]      = inst_q[rd_idx[j]];
            out_pc[j*XLEN +: XLEN]        = pc_q[rd_idx[j]];
            out_exc[j*EXC_W +: EXC_W]     = exc_q[rd_idx[j]];
        end
    end

endmodule

// File: tb/tb_decode_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_inst_queue
//
// Directed bench for decode_inst_queue (DEPTH=8, IN_WIDTH=2, OUT_WIDTH=2).
// A vector table covers admission, exception zeroing, full/refill and
// wrap-around; hand-written sequences cover streaming, flush and async reset.
// -----------------------------------------------------------------------------
module tb_decode_inst_queue;

    localparam int DEPTH     = 8;
    localparam int IN_WIDTH  = 2;
    localparam int OUT_WIDTH = 2;
    localparam int XLEN      = 32;
    localparam int EXC_W     = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic [IN_WIDTH-1:0]         in_valid;
    logic [IN_WIDTH*XLEN-1:0]    in_inst;
    logic [IN_WIDTH*XLEN-1:0]    in_pc;
    logic [IN_WIDTH*EXC_W-1:0]   in_exc;
    logic                        in_allowin;
    logic [OUT_WIDTH-1:0]        out_valid;
    logic [OUT_WIDTH*XLEN-1:0]   out_inst;
    logic [OUT_WIDTH*XLEN-1:0]   out_pc;
    logic [OUT_WIDTH*EXC_W-1:0]  out_exc;
    logic [1:0]                  out_take;
    logic [3:0]                  count;

    int n_checks = 0;
    int n_errors = 0;

    decode_inst_queue #(
        .DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .XLEN(XLEN), .EXC_W(EXC_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_exc(in_exc),
        .in_allowin(in_allowin),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_exc(out_exc), .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    // Illegal-stimulus guards: contiguous fetch lanes, no over-consumption.
    always @(posedge clk) begin
        if (rst) begin
            assert (((in_valid + 1) & in_valid) == 0)
                else $error("non-contiguous in_valid %b", in_valid);
            assert (out_take <= $countones(out_valid))
                else $error("out_take %0d exceeds out_valid %b", out_take, out_valid);
        end
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] vld,
                         input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [3:0] exc0, input logic [1:0] take);
        flush    = fl;
        in_valid = vld;
        in_pc    = {pc1, pc0};
        in_inst  = {inst_of(pc1), inst_of(pc0)};
        in_exc   = {4'd0, exc0};
        out_take = take;
    endtask

    typedef struct {
        logic        flush;
        logic [1:0]  vld;
        logic [31:0] pc0, pc1, inst0;
        logic [3:0]  exc0;
        logic [1:0]  take;
        logic [3:0]  e_count;
        logic [1:0]  e_valid;
        logic        e_allow;
        logic        chk0;
        logic [31:0] e_pc0;
        logic [3:0]  e_exc0;
        logic        chk1;
        logic [31:0] e_pc1;
    } vec_t;

    localparam logic [31:0] B = 32'h1c00_0000;
    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] pc0, input logic [31:0] pc1,
                                input logic [3:0] exc0, input logic [1:0] take,
                                input logic [3:0] e_count, input logic [1:0] e_valid, input logic e_allow,
                                input logic chk0, input logic [31:0] e_pc0, input logic [3:0] e_exc0,
                                input logic chk1, input logic [31:0] e_pc1);
        vec_t v;
        v.flush = 1'b0; v.vld = vld; v.pc0 = pc0; v.pc1 = pc1;
        v.inst0 = inst_of(pc0); v.exc0 = exc0; v.take = take;
        v.e_count = e_count; v.e_valid = e_valid; v.e_allow = e_allow;
        v.chk0 = chk0; v.e_pc0 = e_pc0; v.e_exc0 = e_exc0;
        v.chk1 = chk1; v.e_pc1 = e_pc1;
        return v;
    endfunction

    // Streaming scoreboard state
    logic [31:0] sq [$];
    int          next_in, next_out, cyc, take_n, enq_k;
    logic        alt;

    initial begin
        logic [31:0] e_inst;

        // {vld, pc0, pc1, exc0, take} -> {count, out_valid, allowin, lane0 pc/exc, lane1 pc}
        vecs[0]  = mk(2'b00, 0, 0, 0, 0,            4'd0, 2'b00, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(2'b11, B+'h00, B+'h04, 0, 0,  4'd2, 2'b11, 1, 1, B+'h00, 0, 1, B+'h04);
        vecs[2]  = mk(2'b00, 0, 0, 0, 2,            4'd0, 2'b00, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(2'b01, B+'h08, 0, 3, 0,       4'd1, 2'b01, 1, 1, B+'h08, 3, 0, 0);
        vecs[4]  = mk(2'b11, B+'h10, B+'h14, 0, 0,  4'd3, 2'b11, 1, 1, B+'h08, 3, 1, B+'h10);
        vecs[5]  = mk(2'b11, B+'h18, B+'h1c, 0, 1,  4'd4, 2'b11, 1, 1, B+'h10, 0, 1, B+'h14);
        vecs[6]  = mk(2'b11, B+'h20, B+'h24, 0, 0,  4'd6, 2'b11, 1, 1, B+'h10, 0, 1, B+'h14);
        vecs[7]  = mk(2'b01, B+'h28, 0, 0, 0,       4'd7, 2'b11, 0, 1, B+'h10, 0, 1, B+'h14);
        vecs[8]  = mk(2'b11, B+'h2c, B+'h30, 0, 0,  4'd7, 2'b11, 0, 1, B+'h10, 0, 1, B+'h14);
        vecs[9]  = mk(2'b00, 0, 0, 0, 1,            4'd6, 2'b11, 1, 1, B+'h14, 0, 1, B+'h18);
        vecs[10] = mk(2'b11, B+'h2c, B+'h30, 0, 0,  4'd8, 2'b11, 0, 1, B+'h14, 0, 1, B+'h18);
        vecs[11] = mk(2'b11, 32'h9999_0000, 32'h9999_0004, 0, 0,
                                                    4'd8, 2'b11, 0, 1, B+'h14, 0, 1, B+'h18);
        vecs[12] = mk(2'b00, 0, 0, 0, 1,            4'd7, 2'b11, 0, 1, B+'h18, 0, 1, B+'h1c);
        vecs[13] = mk(2'b00, 0, 0, 0, 1,            4'd6, 2'b11, 1, 1, B+'h1c, 0, 1, B+'h20);
        vecs[14] = mk(2'b00, 0, 0, 0, 2,            4'd4, 2'b11, 1, 1, B+'h24, 0, 1, B+'h28);
        vecs[15] = mk(2'b11, B+'h34, B+'h38, 0, 2,  4'd4, 2'b11, 1, 1, B+'h2c, 0, 1, B+'h30);
        vecs[16] = mk(2'b00, 0, 0, 0, 2,            4'd2, 2'b11, 1, 1, B+'h34, 0, 1, B+'h38);
        vecs[17] = mk(2'b00, 0, 0, 0, 2,            4'd0, 2'b00, 1, 0, 0, 0, 0, 0);
        vecs[3].inst0 = 32'hDEAD_BEEF;

        // ---------------- reset ----------------
        rst = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset count", 32'(count), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset in_allowin", 32'(in_allowin), 1);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- vector table ----------------
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(vecs[k].flush, vecs[k].vld, vecs[k].pc0, vecs[k].pc1, vecs[k].exc0, vecs[k].take);
            in_inst[31:0] = vecs[k].inst0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d count", k), 32'(count), 32'(vecs[k].e_count));
            check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].e_valid));
            check($sformatf("v%0d in_allowin", k), 32'(in_allowin), 32'(vecs[k].e_allow));
            if (vecs[k].chk0) begin
                e_inst = (vecs[k].e_exc0 != 0) ? 32'h0 : inst_of(vecs[k].e_pc0);
                check($sformatf("v%0d lane0 pc", k), out_pc[31:0], vecs[k].e_pc0);
                check($sformatf("v%0d lane0 inst", k), out_inst[31:0], e_inst);
                check($sformatf("v%0d lane0 exc", k), 32'(out_exc[3:0]), 32'(vecs[k].e_exc0));
            end
            if (vecs[k].chk1) begin
                check($sformatf("v%0d lane1 pc", k), out_pc[63:32], vecs[k].e_pc1);
                check($sformatf("v%0d lane1 inst", k), out_inst[63:32], inst_of(vecs[k].e_pc1));
            end
        end

        // ---------------- stream 20 pcs, take 1/2 alternately ----------------
        next_in = 0; next_out = 0; cyc = 0; alt = 1'b0;
        sq.delete();
        while (next_out < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check("stream count", 32'(count), 32'(sq.size()));
            check("stream in_allowin", 32'(in_allowin), 32'((DEPTH - sq.size()) >= IN_WIDTH));
            take_n = alt ? 2 : 1;
            if (take_n > sq.size()) take_n = sq.size();
            alt = ~alt;
            for (int j = 0; j < take_n; j++) begin
                check("stream pc", out_pc[j*32 +: 32], 32'h2000_0000 + 32'(4 * next_out));
                next_out++;
                void'(sq.pop_front());
            end
            enq_k = 0;
            if ((DEPTH - (sq.size() + take_n)) >= 0 && (DEPTH - int'(count)) >= IN_WIDTH)
                enq_k = (20 - next_in >= 2) ? 2 : (20 - next_in);
            drive(0, (enq_k == 2) ? 2'b11 : (enq_k == 1) ? 2'b01 : 2'b00,
                  32'h2000_0000 + 32'(4 * next_in), 32'h2000_0000 + 32'(4 * (next_in + 1)),
                  0, 2'(take_n));
            for (int j = 0; j < enq_k; j++) begin
                sq.push_back(32'h2000_0000 + 32'(4 * next_in));
                next_in++;
            end
        end
        check("stream completed within budget", 32'(next_out), 20);
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        check("stream drained", 32'(count), 0);

        // ---------------- flush with concurrent enq/deq ----------------
        drive(0, 2'b11, 32'h300, 32'h304, 0, 0);
        @(negedge clk);
        drive(0, 2'b11, 32'h308, 32'h30c, 0, 0);
        @(negedge clk);
        drive(0, 2'b01, 32'h310, 0, 0, 0);
        @(negedge clk);
        check("pre-flush count", 32'(count), 5);
        drive(1, 2'b11, 32'h314, 32'h318, 0, 2);
        @(negedge clk);
        check("post-flush count", 32'(count), 0);
        check("post-flush out_valid", 32'(out_valid), 0);
        check("post-flush in_allowin", 32'(in_allowin), 1);
        drive(0, 2'b01, 32'h400, 0, 0, 0);
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0, 0);
        check("after-flush out_valid", 32'(out_valid), 32'b01);
        check("after-flush count", 32'(count), 1);
        check("after-flush lane0 pc", out_pc[31:0], 32'h400);
        check("after-flush lane0 inst", out_inst[31:0], inst_of(32'h400));

        // ---------------- async reset mid-operation ----------------
        #2;
        rst = 1'b0;
        #1;
        check("async reset count", 32'(count), 0);
        check("async reset out_valid", 32'(out_valid), 0);
        check("async reset in_allowin", 32'(in_allowin), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset idle count", 32'(count), 0);
        check("post-reset idle out_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
